digit_serial_adder: RTL and testbench
=====================================

Name: digit_serial_adder

Overview:
- Parametrised, multi-cycle successor to the single-bit combinational full adder.
- Adds or subtracts two WIDTH-bit operands one DIGIT-bit slice per clock, LSB slice first, with a registered carry between slices.
- Sits between the operand input registers and the hex display path of the 8-bit hex adder.
- Uses a Start/Busy/Done handshake and reports carry-out and signed overflow.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle (4 = one hex digit); 1 <= DIGIT <= WIDTH.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  reset; asynchronous, active-high.
- Start  in  1  request; sampled only when Busy=0.
- Sub  in  1  mode at Start: 0 = add, 1 = subtract.
- In1  in  WIDTH  first operand, sampled at Start.
- In2  in  WIDTH  second operand, sampled at Start.
- InC  in  1  carry-in, sampled at Start.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle pulse: result valid.
- R  out  WIDTH  result; held until the next accepted Start.
- OutC  out  1  carry-out of the MSB (not-borrow when Sub=1).
- Ovf  out  1  two's-complement overflow.

Behaviour:
- Reset (async, Rst=1): state IDLE; Busy=0, Done=0, R=0, OutC=0, Ovf=0; internal operand, carry and slice-index registers = 0. Reset mid-operation aborts with no Done pulse.
- NDIG = WIDTH/DIGIT slices. An illegal parameter combination is an elaboration error.
- Arithmetic:
  - Sub=0: {OutC,R} = In1 + In2 + InC.
  - Sub=1: {OutC,R} = In1 + ~In2 + InC. The caller drives InC=1 for a plain A-B.
  - In2 is inverted once at load.
  - Ovf = (A[MSB] == B'[MSB]) && (R[MSB] != A[MSB]), where B' is the (possibly inverted) second operand.
- States:
  - IDLE: Busy=0. Start=1 -> latch In1, In2 (inverted if Sub), InC into the carry register; slice index = 0; go to RUN; Busy=1 from the next cycle.
  - RUN: on each edge, add slice[index] of both operands plus the carry register. Write the sum slice into the result shift register and update the carry register. After slice NDIG-1, go to DONE.
  - DONE: lasts one cycle; Done=1, Busy=0. R, OutC and Ovf are updated at the edge entering DONE. Start=1 in DONE is accepted exactly as in IDLE (back-to-back). Otherwise go to IDLE.
- Latency: Done is high exactly NDIG+1 cycles after the edge that samples Start. Sustained throughput is one result per NDIG+1 cycles.
- Start while Busy=1 is ignored; operand changes during RUN have no effect.
- R, OutC and Ovf change only at the edge entering DONE and are stable at all other times, including in IDLE.
- Done never asserts for two consecutive cycles.
- DIGIT == WIDTH degenerates to a single RUN cycle; the same handshake applies.
- The slice adder is a behavioural DIGIT-bit add with carry. No combinational path exists from inputs to outputs.

Test Plan:
- WIDTH=8, DIGIT=4; Start with In1=0x3A, In2=0x47, InC=0, Sub=0 -> Done 3 cycles after Start edge; R=0x81, OutC=0, Ovf=1; Busy high for 2 cycles.
- WIDTH=8, DIGIT=4; In1=0xFF, In2=0x01, InC=0, Sub=0 -> R=0x00, OutC=1, Ovf=0. Then In1=0x10, In2=0x20, InC=1, Sub=1 -> R=0xF0, OutC=0, Ovf=0.
- Back-to-back: second Start (In1=0x01, In2=0x02) held high in the DONE cycle of the first op -> accepted; second Done 3 cycles later with R=0x03. Start pulses asserted mid-RUN -> no extra Done.
- Reset mid-op: assert Rst asynchronously during RUN of 0x55+0x55 -> Busy, Done, R, OutC and Ovf go to 0 immediately; no Done pulse; a fresh Start after release gives the correct result (0xAA, Ovf=1).
- Parametric: WIDTH=16, DIGIT=4, In1=0xFFFF, In2=0x0000, InC=1 -> R=0x0000, OutC=1, Done at 5 cycles. WIDTH=8, DIGIT=1, 0x7F+0x01 -> R=0x80, Ovf=1, Done at 9 cycles.
- Random: 1000 random In1/In2/InC/Sub vectors for each of (8,4), (8,1), (16,8) compared against a reference model; R, OutC and Ovf must match and be stable between Done pulses.

Source files
------------

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice per clock, LSB slice first,
// with a registered carry between slices and a Start/Busy/Done handshake.
module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             InC,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] R,
  output logic             OutC,
  output logic             Ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  a, b, acc;
  logic              carry;
  logic [IW-1:0]     idx;

  logic [DIGIT-1:0]  a_sl, b_sl;
  logic [DIGIT:0]    slice_sum;
  logic [WIDTH-1:0]  res_nx;
  logic              last;

  always_comb begin
    a_sl      = a[idx*DIGIT +: DIGIT];
    b_sl      = b[idx*DIGIT +: DIGIT];
    slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, carry};
    res_nx    = acc;
    res_nx[idx*DIGIT +: DIGIT] = slice_sum[DIGIT-1:0];
    last      = (idx == IW'(NDIG - 1));
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      acc   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      R     <= '0;
      OutC  <= 1'b0;
      Ovf   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        // DONE accepts a new Start exactly like IDLE so ops can run back-to-back
        IDLE, DONE: begin
          if (Start) begin
            a     <= In1;
            b     <= Sub ? ~In2 : In2;
            carry <= InC;
            idx   <= '0;
            acc   <= '0;
            Busy  <= 1'b1;
            state <= RUN;
          end else begin
            Busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= res_nx;
          carry <= slice_sum[DIGIT];
          idx   <= idx + IW'(1);
          if (last) begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
            R     <= res_nx;
            OutC  <= slice_sum[DIGIT];
            Ovf   <= (a[WIDTH-1] == b[WIDTH-1]) && (res_nx[WIDTH-1] != a[WIDTH-1]);
            state <= DONE;
          end
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: four configurations share one stimulus stream and
// are checked every cycle against an arithmetic model plus directed literal checks.
module tb_digit_serial_adder;

  logic        clk, rst, start, sub, inc;
  logic [15:0] in1, in2;
  logic [3:0]  busy, done, outc, ovf;
  logic [7:0]  r0, r1;
  logic [15:0] r2, r3;
  logic [15:0] r [4];

  int checks = 0;
  int failures = 0;

  // configs: u0 (8,4) u1 (8,1) u2 (16,8) u3 (16,4)
  digit_serial_adder #(.WIDTH(8), .DIGIT(4)) u0 (.Clk(clk), .Rst(rst), .Start(start), .Sub(sub),
    .In1(in1[7:0]), .In2(in2[7:0]), .InC(inc), .Busy(busy[0]), .Done(done[0]), .R(r0),
    .OutC(outc[0]), .Ovf(ovf[0]));
  digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u1 (.Clk(clk), .Rst(rst), .Start(start), .Sub(sub),
    .In1(in1[7:0]), .In2(in2[7:0]), .InC(inc), .Busy(busy[1]), .Done(done[1]), .R(r1),
    .OutC(outc[1]), .Ovf(ovf[1]));
  digit_serial_adder #(.WIDTH(16), .DIGIT(8)) u2 (.Clk(clk), .Rst(rst), .Start(start), .Sub(sub),
    .In1(in1), .In2(in2), .InC(inc), .Busy(busy[2]), .Done(done[2]), .R(r2),
    .OutC(outc[2]), .Ovf(ovf[2]));
  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u3 (.Clk(clk), .Rst(rst), .Start(start), .Sub(sub),
    .In1(in1), .In2(in2), .InC(inc), .Busy(busy[3]), .Done(done[3]), .R(r3),
    .OutC(outc[3]), .Ovf(ovf[3]));

  assign r[0] = {8'h00, r0};
  assign r[1] = {8'h00, r1};
  assign r[2] = r2;
  assign r[3] = r3;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int wof(int k);
    return (k < 2) ? 8 : 16;
  endfunction

  function automatic int nof(int k);
    case (k)
      0:       return 2;
      1:       return 8;
      2:       return 2;
      default: return 4;
    endcase
  endfunction

  // returns {ovf, carry-out, result}
  function automatic logic [17:0] ref_op(int w, logic [15:0] a, logic [15:0] b, logic s, logic c);
    logic [16:0] mask, full;
    logic [15:0] aa, bb, rr;
    logic        co, ov;
    mask = (17'h1 << w) - 17'h1;
    aa   = a & mask[15:0];
    bb   = (s ? ~b : b) & mask[15:0];
    full = {1'b0, aa} + {1'b0, bb} + {16'h0, c};
    rr   = full[15:0] & mask[15:0];
    co   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (rr[w-1] != aa[w-1]);
    return {ov, co, rr};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // model: cycle position per instance (0 idle, 1..N run, N+1 done) and visible results
  int          mcnt [4];
  logic [17:0] pv   [4];
  logic [17:0] ev   [4];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        mcnt[k] <= 0;
        pv[k]   <= '0;
        ev[k]   <= '0;
      end else if ((mcnt[k] == 0 || mcnt[k] == nof(k) + 1) && start) begin
        mcnt[k] <= 1;
        pv[k]   <= ref_op(wof(k), in1, in2, sub, inc);
      end else if (mcnt[k] == nof(k) + 1) begin
        mcnt[k] <= 0;
      end else if (mcnt[k] != 0) begin
        mcnt[k] <= mcnt[k] + 1;
        if (mcnt[k] == nof(k)) ev[k] <= pv[k];
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("u%0d_busy", k), 32'(busy[k]), 32'(mcnt[k] >= 1 && mcnt[k] <= nof(k)));
        chk($sformatf("u%0d_done", k), 32'(done[k]), 32'(mcnt[k] == nof(k) + 1));
        chk($sformatf("u%0d_r", k),    32'(r[k]),    32'(ev[k][15:0]));
        chk($sformatf("u%0d_outc", k), 32'(outc[k]), 32'(ev[k][16]));
        chk($sformatf("u%0d_ovf", k),  32'(ovf[k]),  32'(ev[k][17]));
      end
    end
  end

  task automatic go(logic [15:0] a, logic [15:0] b, logic s, logic c);
    @(posedge clk);
    #2 in1 = a; in2 = b; sub = s; inc = c; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  // latency counts the sampling edge as 1; returns at the negedge where Done is high
  task automatic wait_done(int k, int budget, output int lat, output int bcy);
    lat = 1;
    bcy = 0;
    while (1) begin
      @(negedge clk);
      bcy += int'(busy[k]);
      if (done[k]) break;
      if (lat >= budget) begin
        chk($sformatf("u%0d_timeout", k), 32'd0, 32'd1);
        break;
      end
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic settle();
    repeat (12) @(posedge clk);
  endtask

  int lat, bcy, npulse;
  logic [15:0] rcap;

  initial begin
    rst = 1'b0; start = 1'b0; sub = 1'b0; inc = 1'b0; in1 = '0; in2 = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_r0",   32'(r0),   32'd0);
    chk("rst_r3",   32'(r3),   32'd0);
    chk("rst_flags", 32'({outc, ovf}), 32'd0);
    chk("model_3a47", 32'(ref_op(8, 16'h3A, 16'h47, 1'b0, 1'b0)), 32'h2_0081);
    chk("model_sub",  32'(ref_op(8, 16'h10, 16'h20, 1'b1, 1'b1)), 32'h0_00F0);
    chk("model_ffff", 32'(ref_op(16, 16'hFFFF, 16'h0000, 1'b0, 1'b1)), 32'h1_0000);
    #20 rst = 1'b0;

    go(16'h3A, 16'h47, 1'b0, 1'b0);
    wait_done(0, 20, lat, bcy);
    chk("t1_lat", 32'(lat), 32'd3);
    chk("t1_busy_cycles", 32'(bcy), 32'd2);
    chk("t1_r", 32'(r0), 32'h81);
    chk("t1_c_o", 32'({outc[0], ovf[0]}), 32'b01);
    settle();

    go(16'hFF, 16'h01, 1'b0, 1'b0);
    wait_done(0, 20, lat, bcy);
    chk("t2_r", 32'(r0), 32'h00);
    chk("t2_c_o", 32'({outc[0], ovf[0]}), 32'b10);
    settle();
    go(16'h10, 16'h20, 1'b1, 1'b1);
    wait_done(0, 20, lat, bcy);
    chk("t3_r", 32'(r0), 32'hF0);
    chk("t3_c_o", 32'({outc[0], ovf[0]}), 32'b00);
    settle();

    go(16'hFFFF, 16'h0000, 1'b0, 1'b1);
    wait_done(3, 20, lat, bcy);
    chk("t4_lat", 32'(lat), 32'd5);
    chk("t4_r", 32'(r3), 32'h0000);
    chk("t4_c", 32'(outc[3]), 32'd1);
    settle();
    go(16'h7F, 16'h01, 1'b0, 1'b0);
    wait_done(1, 20, lat, bcy);
    chk("t5_lat", 32'(lat), 32'd9);
    chk("t5_r", 32'(r1), 32'h80);
    chk("t5_o", 32'(ovf[1]), 32'd1);
    settle();

    // back-to-back: second Start presented during the DONE cycle of u0
    go(16'h05, 16'h06, 1'b0, 1'b0);
    wait_done(0, 20, lat, bcy);
    chk("t6a_r", 32'(r0), 32'h0B);
    in1 = 16'h01; in2 = 16'h02; sub = 1'b0; inc = 1'b0; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    wait_done(0, 20, lat, bcy);
    chk("t6b_lat", 32'(lat), 32'd3);
    chk("t6b_r", 32'(r0), 32'h03);
    settle();

    // Start held into the first RUN cycle with new operands must be ignored
    @(posedge clk);
    #2 in1 = 16'h11; in2 = 16'h22; start = 1'b1;
    @(posedge clk);
    #2 in1 = 16'h77; in2 = 16'h77;
    @(posedge clk);
    #2 start = 1'b0;
    npulse = 0;
    rcap = '0;
    repeat (10) begin
      @(negedge clk);
      if (done[0]) begin npulse++; rcap = r[0]; end
    end
    chk("t7_pulses", 32'(npulse), 32'd1);
    chk("t7_r", 32'(rcap), 32'h33);
    settle();

    // asynchronous reset during RUN
    go(16'h55, 16'h55, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("t8_busy", 32'(busy), 32'd0);
    chk("t8_r0", 32'(r0), 32'd0);
    chk("t8_flags", 32'({outc, ovf, done}), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    npulse = 0;
    repeat (6) begin
      @(negedge clk);
      if (done[0]) npulse++;
    end
    chk("t8_no_done", 32'(npulse), 32'd0);
    go(16'h55, 16'h55, 1'b0, 1'b0);
    wait_done(0, 20, lat, bcy);
    chk("t9_r", 32'(r0), 32'hAA);
    chk("t9_c_o", 32'({outc[0], ovf[0]}), 32'b01);
    settle();

    // random stream; gaps vary so the slow instance sees both back-to-back and ignored Starts
    for (int i = 0; i < 1000; i++) begin
      go(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(5, 9)) @(posedge clk);
    end
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
